// File: rtl/pht_write_scheduler.sv
// pht_write_scheduler
// Owns every write port of the banked PHT/GHT counter RAM. After reset it sweeps
// INIT_VALUE into all entries. It then maps up to REQ_NUM counter updates per cycle
// onto one write port per bank. Updates that hit a busy bank, or that would overtake
// an older pending write to the same index, wait in an in-order overflow queue.
module pht_write_scheduler #(
    parameter int ENTRY_NUM   = 2048,
    parameter int INDEX_W     = 11,
    parameter int VALUE_W     = 2,
    parameter int REQ_NUM     = 2,
    parameter int BANK_NUM    = 2,
    parameter int QUEUE_DEPTH = 8,
    parameter int INIT_VALUE  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REQ_NUM-1:0]            req_valid,
    input  logic [REQ_NUM*INDEX_W-1:0]    req_index,
    input  logic [REQ_NUM*VALUE_W-1:0]    req_value,
    output logic [BANK_NUM-1:0]           wr_en,
    output logic [BANK_NUM*INDEX_W-1:0]   wr_addr,
    output logic [BANK_NUM*VALUE_W-1:0]   wr_value,
    output logic                          init_busy,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
    output logic                          drop
);

    localparam int BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [BANK_W-1:0] BANK_MASK = BANK_W'(BANK_NUM - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    // Per-slot views of the flattened request buses
    logic [INDEX_W-1:0] req_idx_a [REQ_NUM];
    logic [VALUE_W-1:0] req_val_a [REQ_NUM];

    // Overflow queue storage; every live entry is visible for index matching
    logic [INDEX_W-1:0] q_idx [QUEUE_DEPTH];
    logic [VALUE_W-1:0] q_val [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_valid;

    // Registered state
    state_t             state_q, state_d;
    logic [INDEX_W-1:0] init_ptr_q, init_ptr_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               init_busy_q, init_busy_d;
    logic               drop_q, drop_d;
    logic [BANK_NUM-1:0] wr_en_q, wr_en_d;
    logic [INDEX_W-1:0] wr_addr_q [BANK_NUM];
    logic [INDEX_W-1:0] wr_addr_d [BANK_NUM];
    logic [VALUE_W-1:0] wr_value_q [BANK_NUM];
    logic [VALUE_W-1:0] wr_value_d [BANK_NUM];

    // Queue write strobes produced by this cycle's evaluation
    logic [REQ_NUM-1:0] push_en;
    logic [PTR_W-1:0]   push_pos [REQ_NUM];

    genvar gi;
    generate
        for (gi = 0; gi < REQ_NUM; gi++) begin : g_req
            assign req_idx_a[gi] = req_index[gi*INDEX_W +: INDEX_W];
            assign req_val_a[gi] = req_value[gi*VALUE_W +: VALUE_W];
        end
        for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_qvalid
            logic [PTR_W-1:0] offset;
            assign offset      = PTR_W'(gi) - head_q;
            assign q_valid[gi] = ({1'b0, offset} < count_q);
        end
        for (gi = 0; gi < BANK_NUM; gi++) begin : g_out
            assign wr_addr[gi*INDEX_W +: INDEX_W]  = wr_addr_q[gi];
            assign wr_value[gi*VALUE_W +: VALUE_W] = wr_value_q[gi];
        end
    endgenerate

    assign wr_en       = wr_en_q;
    assign init_busy   = init_busy_q;
    assign queue_count = count_q;
    assign drop        = drop_q;

    // Next-state evaluation: init sweep, or pop-then-direct-then-push arbitration
    always_comb begin
        logic [BANK_NUM-1:0] bank_busy;
        logic [CNT_W-1:0]    occ;
        logic [PTR_W-1:0]    tail_w;
        logic                pop;
        logic                conflict;
        logic [BANK_W-1:0]   bk;

        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        init_busy_d = init_busy_q;
        drop_d      = 1'b0;
        wr_en_d     = '0;
        push_en     = '0;
        bank_busy   = '0;
        occ         = count_q;
        tail_w      = tail_q;
        pop         = 1'b0;
        conflict    = 1'b0;
        bk          = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            wr_addr_d[b]  = '0;
            wr_value_d[b] = '0;
        end
        for (int s = 0; s < REQ_NUM; s++) begin
            push_pos[s] = '0;
        end

        if (state_q == ST_INIT) begin
            // Requests are ignored while the sweep owns every bank
            wr_en_d = '1;
            for (int b = 0; b < BANK_NUM; b++) begin
                wr_addr_d[b]  = init_ptr_q + INDEX_W'(b);
                wr_value_d[b] = VALUE_W'(INIT_VALUE);
            end
            init_ptr_d = init_ptr_q + INDEX_W'(BANK_NUM);
            if (init_ptr_q == INDEX_W'(ENTRY_NUM - BANK_NUM)) begin
                state_d     = ST_RUN;
                init_busy_d = 1'b0;
            end
        end else begin
            // Oldest deferred write always goes first
            pop = (count_q != '0);
            if (pop) begin
                bk                = q_idx[head_q][BANK_W-1:0] & BANK_MASK;
                bank_busy[bk]     = 1'b1;
                wr_en_d[bk]       = 1'b1;
                wr_addr_d[bk]     = q_idx[head_q];
                wr_value_d[bk]    = q_val[head_q];
            end
            occ = count_q - CNT_W'(pop);

            for (int s = 0; s < REQ_NUM; s++) begin
                // A slot may not overtake any older write to the same index,
                // whether it is queued (head included) or in an earlier slot
                conflict = 1'b0;
                for (int e = 0; e < QUEUE_DEPTH; e++) begin
                    if (q_valid[e] && (q_idx[e] == req_idx_a[s])) begin
                        conflict = 1'b1;
                    end
                end
                for (int t = 0; t < REQ_NUM; t++) begin
                    if ((t < s) && req_valid[t] && (req_idx_a[t] == req_idx_a[s])) begin
                        conflict = 1'b1;
                    end
                end

                if (req_valid[s]) begin
                    bk = req_idx_a[s][BANK_W-1:0] & BANK_MASK;
                    if (!conflict && !bank_busy[bk]) begin
                        bank_busy[bk]  = 1'b1;
                        wr_en_d[bk]    = 1'b1;
                        wr_addr_d[bk]  = req_idx_a[s];
                        wr_value_d[bk] = req_val_a[s];
                    end else if (occ < CNT_W'(QUEUE_DEPTH)) begin
                        push_en[s]  = 1'b1;
                        push_pos[s] = tail_w;
                        tail_w      = tail_w + PTR_W'(1);
                        occ         = occ + CNT_W'(1);
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end

            head_d  = head_q + PTR_W'(pop);
            tail_d  = tail_w;
            count_d = occ;
        end
    end

    // Control and output registers; reset restarts the sweep and empties the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            init_busy_q <= 1'b1;
            drop_q      <= 1'b0;
            wr_en_q     <= '0;
            for (int b = 0; b < BANK_NUM; b++) begin
                wr_addr_q[b]  <= '0;
                wr_value_q[b] <= '0;
            end
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            init_busy_q <= init_busy_d;
            drop_q      <= drop_d;
            wr_en_q     <= wr_en_d;
            for (int b = 0; b < BANK_NUM; b++) begin
                wr_addr_q[b]  <= wr_addr_d[b];
                wr_value_q[b] <= wr_value_d[b];
            end
        end
    end

    // Queue payload storage; stale contents are harmless because count gates validity
    always_ff @(posedge clk) begin
        for (int s = 0; s < REQ_NUM; s++) begin
            if (push_en[s]) begin
                q_idx[push_pos[s]] <= req_idx_a[s];
                q_val[push_pos[s]] <= req_val_a[s];
            end
        end
    end

endmodule
